// File: rtl/bcd_clock_core.sv
// bcd_clock_core: BCD HH:MM:SS time-of-day core with button edit mode and 12/24-hour display.
// Digit index 0..5 = hrL, hrR, mL, mR, sL, sR throughout.
module bcd_clock_core #(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27,
    parameter bit EDIT_SEC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fmt12,
    input  logic       bL,
    input  logic       bR,
    input  logic       bC,
    input  logic       bD,
    output logic       edit,
    output logic [2:0] cursor,
    output logic       ampm,
    output logic [3:0] hrL,
    output logic [3:0] hrR,
    output logic [3:0] mL,
    output logic [3:0] mR,
    output logic [3:0] sL,
    output logic [3:0] sR,
    output logic       sec_pulse,
    output logic       day_wrap
);
    typedef enum logic {EDIT, RUN} state_t;

    localparam logic [2:0]       LAST = EDIT_SEC ? 3'd5 : 3'd3;
    localparam logic [CNT_W-1:0] TOP  = CNT_W'(TICK_DIV - 1);

    state_t           st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       cur, cur_n;
    logic [3:0]       t    [6];
    logic [3:0]       t_n  [6];
    logic [3:0]       ti   [6];
    logic [3:0]       v, mx;
    logic             c5, c4, c3, c2, wrap, tick, step;
    logic [4:0]       hb, h12;
    logic             pm;
    logic [3:0]       dh1, dh0;

    // one-second increment with BCD carries through to the day wrap
    always_comb begin
        c5    = t[5] == 4'd9;
        c4    = c5 && t[4] == 4'd5;
        c3    = c4 && t[3] == 4'd9;
        c2    = c3 && t[2] == 4'd5;
        wrap  = c2 && t[0] == 4'd2 && t[1] == 4'd3;
        ti[5] = c5 ? 4'd0 : t[5] + 4'd1;
        ti[4] = c5 ? (c4 ? 4'd0 : t[4] + 4'd1) : t[4];
        ti[3] = c4 ? (c3 ? 4'd0 : t[3] + 4'd1) : t[3];
        ti[2] = c3 ? (c2 ? 4'd0 : t[2] + 4'd1) : t[2];
        ti[1] = !c2 ? t[1] : (wrap || t[1] == 4'd9) ? 4'd0 : t[1] + 4'd1;
        ti[0] = !c2 ? t[0] : wrap ? 4'd0 : t[1] == 4'd9 ? t[0] + 4'd1 : t[0];
    end

    always_comb begin
        tick  = st == RUN && cnt == TOP;
        v     = t[cur];
        mx    = cur == 3'd0 ? 4'd2 : cur == 3'd1 ? (t[0] == 4'd2 ? 4'd3 : 4'd9) : cur[0] ? 4'd9 : 4'd5;
        st_n  = st;
        cur_n = cur;
        cnt_n = '0;
        t_n   = t;
        step  = 1'b0;
        if (st == RUN) begin
            if (bL) begin
                st_n  = EDIT;
                cur_n = '0;
            end else if (bD) begin
                st_n  = EDIT;
                cur_n = '0;
                t_n   = '{default: 4'd0};
            end else if (tick) begin
                t_n  = ti;
                step = 1'b1;
            end else
                cnt_n = cnt + 1'b1;
        end else if (bL) begin
            if (cur == 3'd0) st_n = RUN;
            else cur_n = cur - 3'd1;
        end else if (bR) begin
            if (cur == LAST) begin
                st_n  = RUN;
                cur_n = '0;
            end else
                cur_n = cur + 3'd1;
        end else if (bC)
            t_n[cur] = v >= mx ? 4'd0 : v + 4'd1;
        else if (bD)
            t_n[cur] = v == 4'd0 ? mx : v - 4'd1;
        // hours 24..29 are unreachable: pull hrR down whenever hrL lands on 2
        if (t_n[0] == 4'd2 && t_n[1] > 4'd3) t_n[1] = 4'd3;
        if (!EDIT_SEC && st_n == EDIT) begin
            t_n[4] = 4'd0;
            t_n[5] = 4'd0;
        end
    end

    always_comb begin
        hb  = 5'(t[0]) * 5'd10 + 5'(t[1]);
        pm  = hb >= 5'd12;
        h12 = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
        dh1 = h12 >= 5'd10 ? 4'd1 : 4'd0;
        dh0 = 4'(h12 >= 5'd10 ? h12 - 5'd10 : h12);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= EDIT;
            cnt       <= '0;
            cur       <= '0;
            t         <= '{default: 4'd0};
            edit      <= 1'b1;
            cursor    <= '0;
            ampm      <= 1'b0;
            hrL       <= '0;
            hrR       <= '0;
            mL        <= '0;
            mR        <= '0;
            sL        <= '0;
            sR        <= '0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            cur       <= cur_n;
            t         <= t_n;
            edit      <= st == EDIT;
            cursor    <= cur;
            ampm      <= fmt12 && pm;
            hrL       <= fmt12 ? dh1 : t[0];
            hrR       <= fmt12 ? dh0 : t[1];
            mL        <= t[2];
            mR        <= t[3];
            sL        <= t[4];
            sR        <= t[5];
            sec_pulse <= step;
            day_wrap  <= step && wrap;
        end
    end
endmodule

// File: tb/tb_bcd_clock_core.sv
// tb_bcd_clock_core: directed + random stimulus on two cores (EDIT_SEC=0 and 1) against a time-of-day model.
module tb_bcd_clock_core;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn [2];
    logic       fmt [2];
    logic       ed [2];
    logic [2:0] cu [2];
    logic       ap [2];
    logic [3:0] hl [2];
    logic [3:0] hr [2];
    logic [3:0] ml [2];
    logic [3:0] mr [2];
    logic [3:0] sl [2];
    logic [3:0] sr [2];
    logic       sp [2];
    logic       dw [2];

    int n_vec = 0;
    int n_bad = 0;
    int run [2], cnt [2], cur [2], hh [2], mm [2], ss [2];
    logic [31:0] exp_w [2];

    bcd_clock_core #(.TICK_DIV(TD), .CNT_W(3), .EDIT_SEC(1'b0)) d0 (
        .clk(clk), .rst(rst), .fmt12(fmt[0]),
        .bL(btn[0][3]), .bR(btn[0][2]), .bC(btn[0][1]), .bD(btn[0][0]),
        .edit(ed[0]), .cursor(cu[0]), .ampm(ap[0]),
        .hrL(hl[0]), .hrR(hr[0]), .mL(ml[0]), .mR(mr[0]), .sL(sl[0]), .sR(sr[0]),
        .sec_pulse(sp[0]), .day_wrap(dw[0])
    );

    bcd_clock_core #(.TICK_DIV(TD), .CNT_W(3), .EDIT_SEC(1'b1)) d1 (
        .clk(clk), .rst(rst), .fmt12(fmt[1]),
        .bL(btn[1][3]), .bR(btn[1][2]), .bC(btn[1][1]), .bD(btn[1][0]),
        .edit(ed[1]), .cursor(cu[1]), .ampm(ap[1]),
        .hrL(hl[1]), .hrR(hr[1]), .mL(ml[1]), .mR(mr[1]), .sL(sl[1]), .sR(sr[1]),
        .sec_pulse(sp[1]), .day_wrap(dw[1])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return {1'b0, ed[i], cu[i], ap[i], hl[i], hr[i], ml[i], mr[i], sl[i], sr[i], sp[i], dw[i]};
    endfunction

    function automatic logic [31:0] mk(input bit e, input int c, input int h, input int m, input int s,
                                       input bit f, input bit p, input bit w);
        int dh;
        bit a;
        dh = f ? (h % 12 == 0 ? 12 : h % 12) : h;
        a  = f && h >= 12;
        return {1'b0, e, 3'(c), a, 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p, w};
    endfunction

    function automatic int mdig(input int i, input int c);
        int d [6];
        d = '{hh[i] / 10, hh[i] % 10, mm[i] / 10, mm[i] % 10, ss[i] / 10, ss[i] % 10};
        return d[c];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; cnt[i] = 0; cur[i] = 0; hh[i] = 0; mm[i] = 0; ss[i] = 0;
        end
    endtask

    // outputs after the edge show the pre-edge time; pulses report the event of this edge
    task automatic model_step(input int i);
        int last, t, lim, pc, ph, pm, ps;
        int d [6];
        bit pe, f, p, w;
        logic [3:0] b;
        last = i ? 5 : 3;
        b = btn[i];
        f = fmt[i];
        pe = run[i] == 0; pc = cur[i]; ph = hh[i]; pm = mm[i]; ps = ss[i];
        p = 0; w = 0;
        if (run[i] != 0) begin
            if (b[3]) begin
                run[i] = 0; cur[i] = 0;
            end else if (b[0]) begin
                run[i] = 0; cur[i] = 0; hh[i] = 0; mm[i] = 0; ss[i] = 0;
            end else if (cnt[i] == TD - 1) begin
                cnt[i] = 0;
                t = hh[i] * 3600 + mm[i] * 60 + ss[i] + 1;
                w = t == 86400;
                t = t % 86400;
                hh[i] = t / 3600; mm[i] = (t / 60) % 60; ss[i] = t % 60;
                p = 1;
            end else
                cnt[i]++;
        end else if (b[3]) begin
            if (cur[i] == 0) run[i] = 1;
            else cur[i]--;
        end else if (b[2]) begin
            if (cur[i] == last) begin
                run[i] = 1; cur[i] = 0;
            end else
                cur[i]++;
        end else if (b[1] || b[0]) begin
            d = '{hh[i] / 10, hh[i] % 10, mm[i] / 10, mm[i] % 10, ss[i] / 10, ss[i] % 10};
            lim = cur[i] == 0 ? 2 : cur[i] == 1 ? (d[0] == 2 ? 3 : 9) : (cur[i] % 2 != 0 ? 9 : 5);
            if (b[1]) d[cur[i]] = d[cur[i]] == lim ? 0 : d[cur[i]] + 1;
            else d[cur[i]] = d[cur[i]] == 0 ? lim : d[cur[i]] - 1;
            if (d[0] == 2 && d[1] > 3) d[1] = 3;
            hh[i] = d[0] * 10 + d[1]; mm[i] = d[2] * 10 + d[3]; ss[i] = d[4] * 10 + d[5];
        end
        if (run[i] == 0) cnt[i] = 0;
        if (i == 0 && run[i] == 0) ss[i] = 0;
        exp_w[i] = mk(pe, pc, ph, pm, ps, f, p, w);
    endtask

    task automatic cyc();
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        #1;
        chk("core0", word(0), exp_w[0]);
        chk("core1", word(1), exp_w[1]);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic press(input int i, input logic [3:0] b);
        btn[i] = b;
        cyc();
        btn[i] = 4'b0000;
    endtask

    task automatic set_dig(input int i, input int v);
        for (int k = 0; k < 10 && mdig(i, cur[i]) != v; k++) press(i, 4'b0010);
    endtask

    // from EDIT with cursor 0: dial every digit in, then step past the last one into RUN
    task automatic load(input int i, input int h, input int m, input int s);
        int tg [6];
        tg = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
        for (int c = 0; c <= (i ? 5 : 3); c++) begin
            set_dig(i, tg[c]);
            press(i, 4'b0100);
        end
    endtask

    initial begin
        btn[0] = 4'b0000; btn[1] = 4'b0000;
        fmt[0] = 1'b0; fmt[1] = 1'b0;
        model_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_async0", word(0), mk(1, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_async1", word(1), mk(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("rst_held1", word(1), mk(1, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        press(1, 4'b1000);
        idle(6);

        press(1, 4'b1000);
        press(1, 4'b0010);
        press(1, 4'b0010);
        press(1, 4'b0100);
        press(1, 4'b0001);
        press(1, 4'b0010);
        idle(2);

        press(1, 4'b1000);
        set_dig(1, 1);
        press(1, 4'b0100);
        set_dig(1, 9);
        press(1, 4'b1000);
        press(1, 4'b0010);
        idle(2);

        fmt[1] = 1'b1;
        load(1, 23, 59, 59);
        idle(8);

        press(1, 4'b1000);
        load(1, 13, 0, 0);
        idle(3);
        fmt[1] = 1'b0;
        idle(2);
        fmt[1] = 1'b1;
        idle(1);

        for (int k = 0; k < TD && cnt[1] != TD - 1; k++) cyc();
        press(1, 4'b0001);
        idle(3);

        load(0, 12, 34, 0);
        idle(6);
        press(0, 4'b1000);
        idle(2);

        press(1, 4'b1000);
        idle(2);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid0", word(0), mk(1, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_mid1", word(1), mk(1, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        #1 rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                btn[i] = $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0000;
                if ($urandom_range(0, 40) == 0) fmt[i] = ~fmt[i];
            end
            cyc();
        end
        btn[0] = 4'b0000; btn[1] = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_clock_core.md
Name: bcd_clock_core

Overview:
- Parametrised BCD time-of-day core, successor to the 12/24-hour clock block.
- Keeps HH:MM:SS in BCD and advances it from an internal prescaler.
- Has a button-driven edit mode with a digit cursor and optional seconds editing.
- Drives a registered display bus in 12-hour or 24-hour format. Sits between the debounced button/switch front end and the 7-segment display mux.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick; legal range ≥2.
- CNT_W, 27, prescaler width; must hold TICK_DIV-1.
- EDIT_SEC, 1, 1: cursor covers seconds digits (6 positions); 0: cursor covers HH:MM only (4 positions) and seconds are forced to 00 while editing.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- fmt12  in  1  1 = 12-hour display, 0 = 24-hour display
- bL  in  1  left button, one-cycle pulse (debounced upstream)
- bR  in  1  right button, one-cycle pulse
- bC  in  1  centre button (increment), one-cycle pulse
- bD  in  1  down button (decrement / clear), one-cycle pulse
- edit  out  1  1 while in EDIT state
- cursor  out  3  active edit digit: 0 hrL, 1 hrR, 2 mL, 3 mR, 4 sL, 5 sR
- ampm  out  1  0 AM, 1 PM; always 0 when fmt12=0
- hrL, hrR, mL, mR, sL, sR  out  4 each  displayed BCD digits
- sec_pulse  out  1  one-cycle pulse when seconds advance
- day_wrap  out  1  one-cycle pulse on 23:59:59→00:00:00

Behaviour:
- Reset (async, immediate, also mid-operation):
  - internal time = 00:00:00, state EDIT, cursor 0, prescaler 0.
  - Outputs: all digits 0, ampm 0, edit 1, cursor 0, sec_pulse 0, day_wrap 0.
- Time register is always legal BCD: hours 00–23, minutes 00–59, seconds 00–59.
- States: EDIT, RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. On TICK_DIV-1 it wraps to 0, seconds advance, and sec_pulse=1 in the following cycle.
  - Carries: sR 9→0 increments sL; sL:sR 59→00 increments minutes; 59→00 minutes increments hours; 09→10 and 19→20 handled; 23→00 asserts day_wrap with the same timing as sec_pulse.
  - Priority: bL > bD > tick.
  - bL: go to EDIT, cursor 0, time unchanged, the pending tick is dropped.
  - bD: time=00:00:00, go to EDIT, cursor 0.
  - bR and bC are ignored.
- EDIT:
  - Prescaler held at 0; no ticks, no sec_pulse.
  - LAST = 5 if EDIT_SEC else 3.
  - Priority: bL > bR > bC > bD; one action per cycle.
  - bL: cursor 0 → go to RUN; otherwise cursor-1.
  - bR: cursor LAST → go to RUN with cursor 0; otherwise cursor+1.
  - bC increments the digit at cursor with wrap; bD decrements with wrap.
  - Digit limits: hrL 0..2; hrR 0..9 if hrL<2, else 0..3; mL 0..5; mR 0..9; sL 0..5; sR 0..9.
  - Changing hrL to 2 while hrR>3 clamps hrR to 3 in the same cycle.
  - bD on hrR=0 with hrL=2 yields 3.
- Entering RUN: prescaler starts at 0, so the first tick comes TICK_DIV cycles after the transition cycle.
- Display formatting, all outputs registered, 1-cycle latency from internal state:
  - fmt12=0: hrL:hrR = raw hours, ampm=0.
  - fmt12=1:
    - 00→12, ampm 0.
    - 01–11 shown unchanged, ampm 0.
    - 12 shown as 12, ampm 1.
    - 13–23 shown as hours−12 in BCD (e.g. 20→08, 21→09), ampm 1.
  - Formatting is a single registered stage; there is no intermediate buffer, so fmt12 changes appear on outputs exactly 1 cycle later.
  - mL..sR mirror the internal time; edit and cursor mirror FSM state, all with the same 1-cycle latency.
- Buttons asserted for multiple cycles act once per cycle asserted; pulse shaping is upstream.

Test Plan:
- TICK_DIV=4, EDIT_SEC=1: reset, then bL pulse → edit drops to 0. After 4 cycles sec_pulse fires and sR=1.
- Edit: cursor 0, bC×2 → hrL=2. Then bR, bD → hrR=3; bC → hrR=0.
- Clamp: set 19 (hrL=1, hrR=9), cursor 0, bC → hours=23.
- Exit: bR at cursor 5 → RUN, cursor 0; with EDIT_SEC=0, bR at cursor 3 → RUN and seconds=00.
- Wrap: load 23:59:59, run one tick → 00:00:00 and one-cycle day_wrap. With fmt12=1 the display reads 12:00:00, ampm=0.
- Format: hours 13, fmt12=1 → 01, ampm=1; toggle fmt12=0 → 13, ampm=0 one cycle later.
- Clear and reset: in RUN assert bD together with a tick → time=00:00:00, edit=1, no sec_pulse. Assert rst mid-count → outputs reach their reset values immediately, with no clk edge.
